// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life board store: edit-op encodings and
// parameter helpers used by life_board_store and life_gen_tracker.
package life_pkg;

  typedef enum logic [1:0] {
    EDIT_NOP  = 2'b00,
    EDIT_SET  = 2'b01,
    EDIT_CLR  = 2'b10,
    EDIT_FLIP = 2'b11
  } edit_op_e;

  // Write-back sits three cells before the start of the last row.
  function automatic int default_wb_pos(input int x, input int y);
    return (y - 1) * x - 3;
  endfunction

  function automatic int steps_per_gen(input int x, input int y, input int lanes);
    return (x * y) / lanes;
  endfunction

endpackage

// File: rtl/life_gen_tracker.sv
// Generation tracker: step index within the generation, one-cycle
// generation-complete pulse and a wrapping count of completed generations.
module life_gen_tracker
  import life_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int LANES = 1,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_all,
  input  logic                   step,
  output logic [LOG2X+LOG2Y-1:0] phase,
  output logic                   gen_done,
  output logic [GEN_W-1:0]       gen_count
);

  localparam int              PW   = LOG2X + LOG2Y;
  localparam logic [PW-1:0]   LAST = PW'(steps_per_gen(X, Y, LANES) - 1);

  logic [PW-1:0]    r_phase;
  logic             r_gen_done;
  logic [GEN_W-1:0] r_gen_count;

  // NOTE: state is updated with <= so every flop samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase     <= '0;
      r_gen_done  <= 1'b0;
      r_gen_count <= '0;
    end else if (clear_all) begin
      r_phase     <= '0;
      r_gen_done  <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_gen_done <= 1'b0;
      if (step) begin
        if (r_phase == LAST) begin
          r_phase     <= '0;
          r_gen_done  <= 1'b1;
          r_gen_count <= r_gen_count + 1'b1;
        end else begin
          r_phase <= r_phase + 1'b1;
        end
      end
    end
  end

  assign phase     = r_phase;
  assign gen_done  = r_gen_done;
  assign gen_count = r_gen_count;

endmodule

// File: rtl/life_board_store.sv
// Game-of-Life board register: circular shift store with LANES-wide write-back,
// cell-edit port and generation tracking. Optional LIFE_POPCOUNT_EN adds population.
module life_board_store
  import life_pkg::*;
#(
  parameter int X      = 8,
  parameter int Y      = 8,
  parameter int LOG2X  = 3,
  parameter int LOG2Y  = 3,
  parameter int LANES  = 1,
  parameter int WB_POS = default_wb_pos(X, Y),
  parameter int GEN_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_all,
  input  logic                   step,
  input  logic [LANES-1:0]       new_cells,
  input  logic                   edit_valid,
  output logic                   edit_ready,
  input  logic [1:0]             edit_op,
  input  logic [LOG2X-1:0]       edit_x,
  input  logic [LOG2Y-1:0]       edit_y,
  output logic                   edit_err,
  output logic [X*Y-1:0]         data,
  output logic [LOG2X+LOG2Y-1:0] phase,
  output logic                   gen_done,
  output logic [GEN_W-1:0]       gen_count
`ifdef LIFE_POPCOUNT_EN
  ,
  output logic [LOG2X+LOG2Y:0]   population
`endif
);

  localparam int N  = X * Y;
  localparam int IW = LOG2X + LOG2Y;

  localparam logic [LOG2X:0] X_LIM = (LOG2X + 1)'(X);
  localparam logic [LOG2Y:0] Y_LIM = (LOG2Y + 1)'(Y);

  logic [N-1:0]  r_data;
  logic          r_edit_err;
  logic [N-1:0]  w_data_next;
  logic [IW-1:0] w_phase;
  logic [IW-1:0] w_idx;
  logic          w_in_range;
  logic          w_xfer;
  edit_op_e      w_op;

  life_gen_tracker #(
    .X     (X),
    .Y     (Y),
    .LOG2X (LOG2X),
    .LOG2Y (LOG2Y),
    .LANES (LANES),
    .GEN_W (GEN_W)
  ) u_gen_tracker (
    .clk       (clk),
    .reset     (reset),
    .clear_all (clear_all),
    .step      (step),
    .phase     (w_phase),
    .gen_done  (gen_done),
    .gen_count (gen_count)
  );

  // Edits only at a generation boundary, where logical and physical indices agree.
  assign edit_ready = !step && !clear_all && (w_phase == '0);
  assign w_xfer     = edit_valid && edit_ready;
  assign w_op       = edit_op_e'(edit_op);
  assign w_in_range = ({1'b0, edit_x} < X_LIM) && ({1'b0, edit_y} < Y_LIM);
  assign w_idx      = IW'(edit_y) * IW'(X) + IW'(edit_x);

  always_comb begin
    // NOTE: default assignment first so every path drives w_data_next and
    // no latch is inferred.
    w_data_next = r_data;
    if (clear_all) begin
      w_data_next = '0;
    end else if (step) begin
      w_data_next = {r_data[LANES-1:0], r_data[N-1:LANES]};
      for (int k = 0; k < LANES; k++) begin
        w_data_next[WB_POS+k] = new_cells[k];
      end
    end else if (w_xfer && w_in_range) begin
      case (w_op)
        EDIT_SET:  w_data_next[w_idx] = 1'b1;
        EDIT_CLR:  w_data_next[w_idx] = 1'b0;
        EDIT_FLIP: w_data_next[w_idx] = ~r_data[w_idx];
        default:   w_data_next = r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data     <= '0;
      r_edit_err <= 1'b0;
    end else begin
      r_data     <= w_data_next;
      r_edit_err <= w_xfer && !w_in_range;
    end
  end

  assign data     = r_data;
  assign phase    = w_phase;
  assign edit_err = r_edit_err;

`ifdef LIFE_POPCOUNT_EN
  logic [IW:0] r_population;

  // Counts the registered board, so it trails any data change by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_population <= '0;
    end else if (clear_all) begin
      r_population <= '0;
    end else begin
      r_population <= (IW + 1)'($countones(r_data));
    end
  end

  assign population = r_population;
`endif

endmodule

// File: tb/tb_life_board_store.sv
// Directed bench for life_board_store: 8x8 LANES=1, 8x8 LANES=4 and a 6x8 board.
module tb_life_board_store;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: 8x8, LANES=1
  logic        a_clear, a_step, a_nc, a_ev, a_er, a_err, a_gd;
  logic [1:0]  a_op;
  logic [2:0]  a_x, a_y;
  logic [63:0] a_data;
  logic [5:0]  a_phase;
  logic [15:0] a_gc;
  // Instance B: 8x8, LANES=4
  logic        b_clear, b_step, b_ev, b_er, b_err, b_gd;
  logic [3:0]  b_nc;
  logic [1:0]  b_op;
  logic [2:0]  b_x, b_y;
  logic [63:0] b_data;
  logic [5:0]  b_phase;
  logic [15:0] b_gc;
  // Instance C: 6x8, LANES=1
  logic        c_clear, c_step, c_nc, c_ev, c_er, c_err, c_gd;
  logic [1:0]  c_op;
  logic [2:0]  c_x, c_y;
  logic [47:0] c_data;
  logic [5:0]  c_phase;
  logic [15:0] c_gc;
`ifdef LIFE_POPCOUNT_EN
  logic [6:0]  a_pop, b_pop, c_pop;
`endif

  life_board_store u_dut_a (
    .clk(clk), .reset(reset), .clear_all(a_clear), .step(a_step), .new_cells(a_nc),
    .edit_valid(a_ev), .edit_ready(a_er), .edit_op(a_op), .edit_x(a_x), .edit_y(a_y),
    .edit_err(a_err), .data(a_data), .phase(a_phase), .gen_done(a_gd), .gen_count(a_gc)
`ifdef LIFE_POPCOUNT_EN
    , .population(a_pop)
`endif
  );

  life_board_store #(.LANES(4)) u_dut_b (
    .clk(clk), .reset(reset), .clear_all(b_clear), .step(b_step), .new_cells(b_nc),
    .edit_valid(b_ev), .edit_ready(b_er), .edit_op(b_op), .edit_x(b_x), .edit_y(b_y),
    .edit_err(b_err), .data(b_data), .phase(b_phase), .gen_done(b_gd), .gen_count(b_gc)
`ifdef LIFE_POPCOUNT_EN
    , .population(b_pop)
`endif
  );

  life_board_store #(.X(6)) u_dut_c (
    .clk(clk), .reset(reset), .clear_all(c_clear), .step(c_step), .new_cells(c_nc),
    .edit_valid(c_ev), .edit_ready(c_er), .edit_op(c_op), .edit_x(c_x), .edit_y(c_y),
    .edit_err(c_err), .data(c_data), .phase(c_phase), .gen_done(c_gd), .gen_count(c_gc)
`ifdef LIFE_POPCOUNT_EN
    , .population(c_pop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {a_clear, a_step, a_nc, a_ev, a_op, a_x, a_y} = '0;
    {b_clear, b_step, b_nc, b_ev, b_op, b_x, b_y} = '0;
    {c_clear, c_step, c_nc, c_ev, c_op, c_x, c_y} = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;

    // Reset state
    check("rst_data",  a_data, 64'd0);
    check("rst_phase", 64'(a_phase), 64'd0);
    check("rst_gc",    64'(a_gc), 64'd0);
    check("rst_gd",    64'(a_gd), 64'd0);
    check("rst_err",   64'(a_err), 64'd0);
    check("rst_ready", 64'(a_er), 64'd1);

    // Set x=2,y=3 -> bit 26
    a_ev = 1'b1; a_op = 2'b01; a_x = 3'd2; a_y = 3'd3;
    #1 check("set_ready", 64'(a_er), 64'd1);
    tick();
    a_ev = 1'b0;
    check("set_data", a_data, 64'd1 << 26);

    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("clr_data", a_data, 64'd0);

    // Seed bit 0, then single-lane steps
    a_ev = 1'b1; a_op = 2'b01; a_x = 3'd0; a_y = 3'd0;
    tick();
    a_ev = 1'b0;
    check("seed0", a_data, 64'd1);
    a_step = 1'b1; a_nc = 1'b0;
    tick();
    check("step1_data",  a_data, 64'd1 << 63);
    check("step1_phase", 64'(a_phase), 64'd1);
    a_nc = 1'b1;
    tick();
    check("step2_data", a_data, (64'd1 << 62) | (64'd1 << 53));
    a_step = 1'b0;

    // Paused mid-generation: edit held off
    a_ev = 1'b1; a_op = 2'b01; a_x = 3'd0; a_y = 3'd0;
    #1 check("pause_ready", 64'(a_er), 64'd0);
    tick();
    a_ev = 1'b0;
    check("pause_data", a_data, (64'd1 << 62) | (64'd1 << 53));

    a_step = 1'b1; a_nc = 1'b1;
    tick();
    a_nc = 1'b0;
    tick();
    tick();
    a_step = 1'b0;
    check("ph5_data",  a_data, (64'd1 << 59) | (64'd1 << 51) | (64'd1 << 50));
    check("ph5_phase", 64'(a_phase), 64'd5);
    tick();
`ifdef LIFE_POPCOUNT_EN
    check("pop3", 64'(a_pop), 64'd3);
`endif
    a_clear = 1'b1; a_ev = 1'b1;
    #1 check("clr_ready", 64'(a_er), 64'd0);
    tick();
    a_clear = 1'b0; a_ev = 1'b0;
    check("midclr_data",  a_data, 64'd0);
    check("midclr_phase", 64'(a_phase), 64'd0);
`ifdef LIFE_POPCOUNT_EN
    check("pop0", 64'(a_pop), 64'd0);
`endif

    // B: 16 four-lane steps; edit collides with the final step
    for (int i = 0; i < 16; i++) begin
      b_step = 1'b1;
      if (i == 15) begin
        b_ev = 1'b1; b_op = 2'b11; b_x = 3'd0; b_y = 3'd0;
        #1 check("collide_ready", 64'(b_er), 64'd0);
      end
      tick();
      check($sformatf("gd_%0d", i), 64'(b_gd), (i == 15) ? 64'd1 : 64'd0);
    end
    b_step = 1'b0;
    check("gen_phase", 64'(b_phase), 64'd0);
    check("gen_count", 64'(b_gc), 64'd1);
    check("collide_data", b_data, 64'd0);
    #1 check("after_ready", 64'(b_er), 64'd1);
    tick();
    b_ev = 1'b0;
    check("flip_data", b_data, 64'd1);
    check("gd_low", 64'(b_gd), 64'd0);

    b_step = 1'b1; b_nc = 4'b1010;
    tick();
    check("lane4_data", b_data, (64'd1 << 60) | (64'd1 << 56) | (64'd1 << 54));
    b_nc = 4'b0000;
    repeat (4) tick();
    b_step = 1'b0;
    check("b_ph5", 64'(b_phase), 64'd5);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    check("bclr_data",  b_data, 64'd0);
    check("bclr_phase", 64'(b_phase), 64'd0);
    check("bclr_gc",    64'(b_gc), 64'd0);

    // C: 6-wide board, range checks
    c_ev = 1'b1; c_op = 2'b01; c_x = 3'd7; c_y = 3'd0;
    #1 check("oor_ready", 64'(c_er), 64'd1);
    tick();
    c_ev = 1'b0;
    check("oor_data", 64'(c_data), 64'd0);
    check("oor_err",  64'(c_err), 64'd1);
    tick();
    check("oor_err_drop", 64'(c_err), 64'd0);
    c_ev = 1'b1; c_op = 2'b01; c_x = 3'd6; c_y = 3'd2;
    tick();
    c_ev = 1'b0;
    check("x6_err", 64'(c_err), 64'd1);
    c_ev = 1'b1; c_op = 2'b01; c_x = 3'd5; c_y = 3'd7;
    tick();
    c_ev = 1'b0;
    check("c47_data", 64'(c_data), 64'd1 << 47);
    check("c47_err",  64'(c_err), 64'd0);
    c_ev = 1'b1; c_op = 2'b00; c_x = 3'd1; c_y = 3'd1;
    tick();
    c_ev = 1'b0;
    check("nop_data", 64'(c_data), 64'd1 << 47);
    c_ev = 1'b1; c_op = 2'b10; c_x = 3'd5; c_y = 3'd7;
    tick();
    c_ev = 1'b0;
    check("cclr_data", 64'(c_data), 64'd0);

    // Async reset mid-generation on B
    b_step = 1'b1;
    repeat (19) tick();
    b_step = 1'b0;
    check("pre_rst_gc",    64'(b_gc), 64'd1);
    check("pre_rst_phase", 64'(b_phase), 64'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_phase", 64'(b_phase), 64'd0);
    check("arst_gc",    64'(b_gc), 64'd0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
